// File: rtl/split_n_multicast.sv
// Registered 1-to-N eager fork with per-token destination mask.
// Define SPLIT_N_MULTICAST_SKID_EN for a 2-entry FIFO that registers data_in_ready.
module split_n_multicast #(
    parameter int unsigned N          = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in_data,
    input  logic [N-1:0]          data_in_mask,
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    output logic [DATA_WIDTH-1:0] data_out_data,
    output logic [N-1:0]          data_out_valid,
    input  logic [N-1:0]          data_out_ready,
    output logic                  busy
);

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [N-1:0]          pend_q, pend_d, pend_next;
    logic                  in_fire, load;

    assign pend_next      = pend_q & ~data_out_ready;
    assign data_out_data  = data_q;
    assign data_out_valid = pend_q;
    assign in_fire        = data_in_valid && data_in_ready;
    // Zero-mask tokens are consumed but never stored.
    assign load           = in_fire && (data_in_mask != '0);

`ifdef SPLIT_N_MULTICAST_SKID_EN
    logic [DATA_WIDTH-1:0] data1_q, data1_d;
    logic [N-1:0]          mask1_q, mask1_d;
    logic [1:0]            count_q, count_d;
    logic                  pop;

    assign pop           = (count_q != 2'd0) && (pend_next == '0);
    assign data_in_ready = (count_q < 2'd2) && !rst;
    assign busy          = (count_q != 2'd0);

    always_comb begin
        data_d  = data_q;
        pend_d  = pend_next;
        data1_d = data1_q;
        mask1_d = mask1_q;
        if (pop) begin
            if (count_q == 2'd2) begin
                data_d = data1_q;
                pend_d = mask1_q;
                if (load) begin
                    data1_d = data_in_data;
                    mask1_d = data_in_mask;
                end
            end else if (load) begin
                data_d = data_in_data;
                pend_d = data_in_mask;
            end
        end else if (load) begin
            if (count_q == 2'd0) begin
                data_d = data_in_data;
                pend_d = data_in_mask;
            end else begin
                data1_d = data_in_data;
                mask1_d = data_in_mask;
            end
        end
        count_d = count_q + {1'b0, load} - {1'b0, pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            pend_q  <= '0;
            data1_q <= '0;
            mask1_q <= '0;
            count_q <= 2'd0;
        end else begin
            data_q  <= data_d;
            pend_q  <= pend_d;
            data1_q <= data1_d;
            mask1_q <= mask1_d;
            count_q <= count_d;
        end
    end
`else
    // A new token may load on the same edge the last outstanding output drains.
    assign data_in_ready = (pend_next == '0) && !rst;
    assign busy          = |pend_q;

    always_comb begin
        data_d = data_q;
        pend_d = pend_next;
        if (load) begin
            data_d = data_in_data;
            pend_d = data_in_mask;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            pend_q <= '0;
        end else begin
            data_q <= data_d;
            pend_q <= pend_d;
        end
    end
`endif

endmodule

// File: doc/split_n_multicast.md
Name: split_n_multicast

Overview:
- Registered 1-to-N streaming fork carrying a data payload, with a per-token destination mask.
- Each output drains the token independently (eager fork), so a slow consumer does not force the other consumers to wait in lockstep.
- The input is released once every selected output has taken the token.
- Used wherever one producer feeds several consumers with decoupled backpressure, e.g. broadcasting activations to parallel compute lanes.

Parameters:
- N, 4: number of output channels; legal range is 1 or more.
- DATA_WIDTH, 32: payload width in bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- data_in_data  input  DATA_WIDTH  payload.
- data_in_mask  input  N  destination mask; bit i set means output i must receive the token.
- data_in_valid  input  1  input handshake valid.
- data_in_ready  output  1  input handshake ready.
- data_out_data  output  DATA_WIDTH  payload shared by all outputs (head token).
- data_out_valid  output  N  per-output valid.
- data_out_ready  input  N  per-output ready.
- busy  output  1  high while any token is held.

Behaviour:
- Transfer rules:
  - A transfer occurs on a rising clk edge with valid and ready both high.
  - Input transfer: data_in_valid && data_in_ready.
  - Output i transfer: data_out_valid[i] && data_out_ready[i].
- State (base build): one slot holding data_q[DATA_WIDTH-1:0] and pend_q[N-1:0].
  - pend_q bit i set means output i still owes a transfer.
- Outputs:
  - data_out_data = data_q.
  - data_out_valid = pend_q.
  - busy = |pend_q.
- Per-cycle update:
  - pend_next = pend_q & ~data_out_ready.
  - data_in_ready = (pend_next == 0) && !rst.
  - So a new token may load in the same cycle the last outstanding output transfers. Throughput is 1 token/cycle when all selected outputs are ready.
- Load: on an input transfer with data_in_mask != 0:
  - data_q <= data_in_data.
  - pend_q <= data_in_mask.
  - Latency: input transfer at edge k gives data_out_valid asserted in cycle k+1.
- Hold: otherwise pend_q <= pend_next and data_q is unchanged.
  - data_out_data must stay stable while any bit of pend_q is set.
- Zero mask: an input transfer with data_in_mask == 0 is accepted and discarded.
  - No state change; data_q is not written.
- Unselected outputs: outputs with a clear mask bit never assert valid for that token.
- Output ordering: an output that has already transferred the token keeps valid low until the next token loads, whatever its ready does.
- No combinational path from data_in_valid to data_out_valid.
  - Base build has a combinational path data_out_ready -> data_in_ready only.
- N == 1: behaves as a one-entry register slice with a mask bit; mask 0 drops the token.
- Reset (asserted at any time, including mid-token):
  - pend_q = 0, data_q = 0, data_out_valid = 0, busy = 0, data_in_ready = 0.
  - Outstanding transfers are lost.
  - First acceptance is possible in the first cycle after rst deasserts.
- Protocol: a valid input token (data and mask) must be held stable by the producer until accepted. The bench checks this by assertion; the RTL does not handle violations.

Optional Feature:
- Macro: SPLIT_N_MULTICAST_SKID_EN.
- Defined:
  - The slot becomes a 2-entry FIFO of {data, mask}; the head entry's pend mask drives the outputs.
  - The head pops when its pend_next == 0, and the next entry's mask becomes the head pend in the following cycle.
  - data_in_ready = (entry count < 2) && !rst, computed from registered count only, which removes the data_out_ready -> data_in_ready combinational path.
  - Simultaneous push and pop keeps the count unchanged.
  - Latency into an empty FIFO is still 1 cycle.
  - A zero-mask token is accepted when not full and never enqueued.
  - Reset empties both entries.
- Undefined: base single-slot behaviour above.

Test Plan:
- N=4, all ready=1, stream tokens 0xA0..0xA7 with mask 0xF, valid held high -> each output sees 0xA0..0xA7 in order, one per cycle from cycle 1; data_in_ready stays 1.
- Token 0x55 mask 0b1010; out1 ready=1, out3 ready=0 for 3 cycles -> out1 transfers in cycle 1 and its valid drops; out3 valid high until ready; data_in_ready=0 until the cycle out3 transfers, and the next token loads that same edge.
- Mask 0b0000 token 0x77, then mask 0b0001 token 0x12 -> 0x77 accepted with no output valid and data_q unchanged; out0 receives 0x12, outs1-3 never assert valid.
- Assert rst for 1 cycle while pend_q=0b0110 -> data_out_valid=0, busy=0, data_in_ready=0 during rst; the next token is accepted the cycle after rst deasserts.
- SKID_EN, all outputs stalled, push 3 tokens -> first 2 accepted, data_in_ready=0 after count=2; release ready -> tokens emerge in order, ready returns to 1 one cycle after the first pop.
- N=1, random ready/valid over 1000 tokens -> scoreboard: output sequence equals input tokens with mask=1, no drops or duplicates.
